audio_mix_seq: RTL and testbench

Time-multiplexed sound mixer sequencer for the audio path between the sound sources (8253 timer pulses, beeper, AY, second AY "rs", covox) and the I2S/sigma-delta output stages. On each sample strobe it snapshots all sources and walks a fixed slot list, one slot per clock. Each slot is scaled by a CPU-programmable per-channel 4-bit gain through one shared multiplier and accumulator. The block then emits saturated 16-bit unsigned left/right samples with a one-cycle valid strobe.

---
 rtl/audio_mix_seq.sv | 127 ++++++++++++
 tb/tb_audio_mix_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_seq.sv
// Time-multiplexed 11-slot audio mixer: per-slot L/R 4-bit gains, one shared MAC, saturating output.
// Optional: define AUDIO_MIX_RSOUND_EN to mix the second AY (slots 7-9); otherwise those are skipped.
module audio_mix_seq #(
    parameter int unsigned ACC_W = 17
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic        sample_ce,
    input  logic [3:0]  pulses,
    input  logic [7:0]  ay_soundA,
    input  logic [7:0]  ay_soundB,
    input  logic [7:0]  ay_soundC,
    input  logic [7:0]  rs_soundA,
    input  logic [7:0]  rs_soundB,
    input  logic [7:0]  rs_soundC,
    input  logic [7:0]  covox,
    input  logic        gain_we,
    input  logic [3:0]  gain_addr,
    input  logic [7:0]  gain_data,
    output logic [15:0] o_left,
    output logic [15:0] o_right,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_overrun
);
    localparam int unsigned NSLOT = 11;

    typedef enum logic [1:0] {StIdle, StLatch, StAccum, StOut} state_e;

    state_e           state;
    logic [3:0]       slot;
    logic [7:0]       src  [NSLOT];
    logic [7:0]       gain [NSLOT];
    logic [ACC_W-1:0] acc_l;
    logic [ACC_W-1:0] acc_r;

    logic [7:0]       cur_src;
    logic [7:0]       cur_gain;
    logic [11:0]      prod_l;
    logic [11:0]      prod_r;
    logic [3:0]       slot_next;
    logic [ACC_W:0]   dbl_l;
    logic [ACC_W:0]   dbl_r;

    function automatic logic [7:0] default_gain(input int unsigned idx);
        case (idx)
            4, 7:    return 8'h80;
            6, 9:    return 8'h08;
            default: return 8'h44;
        endcase
    endfunction

    always_comb begin
        cur_src  = src[slot];
        cur_gain = gain[slot];
        prod_l   = 12'(cur_src) * 12'(cur_gain[7:4]);
        prod_r   = 12'(cur_src) * 12'(cur_gain[3:0]);
`ifdef AUDIO_MIX_RSOUND_EN
        slot_next = slot + 4'd1;
`else
        slot_next = (slot == 4'd6) ? 4'd10 : slot + 4'd1;
`endif
        dbl_l = {acc_l, 1'b0};
        dbl_r = {acc_r, 1'b0};
    end

    always_ff @(posedge clk24) begin
        if (reset) begin
            state     <= StIdle;
            slot      <= 4'd0;
            acc_l     <= '0;
            acc_r     <= '0;
            o_left    <= 16'h8000;
            o_right   <= 16'h8000;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                gain[i] <= default_gain(i);
                src[i]  <= 8'h00;
            end
        end else begin
            o_valid   <= 1'b0;
            o_overrun <= sample_ce && (state != StIdle);
            // Busy stays up through the o_valid cycle (state is OUT on the edge before it).
            o_busy    <= (state != StIdle) || sample_ce;

            // A same-cycle ACCUM read sees the old entry; the write lands at this edge.
            if (gain_we && (gain_addr < 4'(NSLOT))) begin
                gain[gain_addr] <= gain_data;
            end

            case (state)
                StIdle: begin
                    if (sample_ce) state <= StLatch;
                end
                StLatch: begin
                    for (int i = 0; i < 4; i++) src[i] <= {8{pulses[i]}};
                    src[4]  <= ay_soundA;
                    src[5]  <= ay_soundB;
                    src[6]  <= ay_soundC;
                    src[7]  <= rs_soundA;
                    src[8]  <= rs_soundB;
                    src[9]  <= rs_soundC;
                    src[10] <= covox;
                    acc_l   <= '0;
                    acc_r   <= '0;
                    slot    <= 4'd0;
                    state   <= StAccum;
                end
                StAccum: begin
                    acc_l <= acc_l + ACC_W'(prod_l);
                    acc_r <= acc_r + ACC_W'(prod_r);
                    slot  <= slot_next;
                    if (slot == 4'd10) state <= StOut;
                end
                StOut: begin
                    o_left  <= (|dbl_l[ACC_W:16]) ? 16'hFFFF : dbl_l[15:0];
                    o_right <= (|dbl_r[ACC_W:16]) ? 16'hFFFF : dbl_r[15:0];
                    o_valid <= 1'b1;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_mix_seq.sv
// Scoreboard bench for audio_mix_seq: stimulus pushes expected samples, a negedge monitor checks them.
module tb_audio_mix_seq;
`ifdef AUDIO_MIX_RSOUND_EN
    localparam int LAT = 14;
    localparam logic [15:0] FULL_EXP = 16'hFFFF;   // 11 * 3825 * 2 saturates
`else
    localparam int LAT = 11;
    localparam logic [15:0] FULL_EXP = 16'hEF10;   // 8 * 3825 * 2 = 61200
`endif

    logic        clk24 = 1'b0;
    logic        reset = 1'b1;
    logic        sample_ce = 1'b0;
    logic [3:0]  pulses = '0;
    logic [7:0]  ay_a = '0, ay_b = '0, ay_c = '0;
    logic [7:0]  rs_a = '0, rs_b = '0, rs_c = '0;
    logic [7:0]  covox = '0;
    logic        gain_we = 1'b0;
    logic [3:0]  gain_addr = '0;
    logic [7:0]  gain_data = '0;
    logic [15:0] o_left, o_right;
    logic        o_valid, o_busy, o_overrun;

    int errors = 0, checks = 0;
    int valid_cnt = 0, busy_cnt = 0, ovr_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    audio_mix_seq dut (
        .clk24(clk24), .reset(reset), .sample_ce(sample_ce), .pulses(pulses),
        .ay_soundA(ay_a), .ay_soundB(ay_b), .ay_soundC(ay_c),
        .rs_soundA(rs_a), .rs_soundB(rs_b), .rs_soundC(rs_c),
        .covox(covox), .gain_we(gain_we), .gain_addr(gain_addr), .gain_data(gain_data),
        .o_left(o_left), .o_right(o_right), .o_valid(o_valid), .o_busy(o_busy),
        .o_overrun(o_overrun)
    );

    always #5 clk24 = ~clk24;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk24) begin
        if (o_busy) busy_cnt++;
        if (o_overrun) ovr_cnt++;
        if (o_valid) begin
            valid_cnt++;
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("left", 32'(o_left), 32'(mon_exp[31:16]));
                check("right", 32'(o_right), 32'(mon_exp[15:0]));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk24); #1 reset = 1'b1;
        repeat (2) @(posedge clk24);
        #1 reset = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk24); #1 sample_ce = 1'b1;
        @(posedge clk24); #1 sample_ce = 1'b0;
    endtask

    task automatic write_gain(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk24); #1 gain_we = 1'b1; gain_addr = a; gain_data = d;
        @(posedge clk24); #1 gain_we = 1'b0;
    endtask

    task automatic set_src(input logic [3:0] p, input logic [7:0] ay, input logic [7:0] rs,
                           input logic [7:0] cv);
        pulses = p; ay_a = ay; ay_b = ay; ay_c = ay;
        rs_a = rs; rs_b = rs; rs_c = rs; covox = cv;
    endtask

    initial begin
        int lat;
        int v0;
        bit found;

        repeat (3) @(posedge clk24);
        #1 reset = 1'b0;
        @(negedge clk24);
        check("rst_left", 32'(o_left), 32'h8000);
        check("rst_right", 32'(o_right), 32'h8000);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);

        // All-zero frame: latency and busy width
        exp_q.push_back(32'h0000_0000);
        busy_cnt = 0;
        start_frame();
        lat = 0;
        found = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk24);
            if (o_valid) begin
                found = 1;
                lat = i;
            end
        end
        check("latency", 32'(lat), 32'(LAT));
        repeat (4) @(posedge clk24);
        @(negedge clk24);
        check("busy_cycles", 32'(busy_cnt), 32'(LAT));

        // Default gains, ay A=B=C=0x80 -> 1536 each side, doubled 3072
        set_src(4'h0, 8'h80, 8'h00, 8'h00);
        exp_q.push_back({16'd3072, 16'd3072});
        start_frame();
        repeat (LAT + 3) @(posedge clk24);

        // Everything full scale with all gains 0xF
        set_src(4'hF, 8'hFF, 8'hFF, 8'hFF);
        for (int i = 0; i < 11; i++) write_gain(4'(i), 8'hFF);
        exp_q.push_back({FULL_EXP, FULL_EXP});
        start_frame();
        repeat (LAT + 3) @(posedge clk24);
        // Out-of-range writes must be dropped
        write_gain(4'd11, 8'h00);
        write_gain(4'd15, 8'h00);
        exp_q.push_back({FULL_EXP, FULL_EXP});
        start_frame();
        repeat (LAT + 3) @(posedge clk24);

        // Gain write to slot 10 on the cycle slot 10 is accumulated
        do_reset();
        set_src(4'h0, 8'h00, 8'h00, 8'h10);
        exp_q.push_back({16'd128, 16'd128});
        start_frame();
        repeat (LAT - 3) @(posedge clk24);
        #1 gain_we = 1'b1; gain_addr = 4'd10; gain_data = 8'hF0;
        @(posedge clk24); #1 gain_we = 1'b0;
        repeat (5) @(posedge clk24);
        exp_q.push_back({16'd480, 16'd0});
        start_frame();
        repeat (LAT + 3) @(posedge clk24);

        // Overrun 5 clocks after start; sources change mid-frame without effect
        do_reset();
        set_src(4'h0, 8'h80, 8'h00, 8'h00);
        @(negedge clk24);
        ovr_cnt = 0;
        v0 = valid_cnt;
        exp_q.push_back({16'd3072, 16'd3072});
        start_frame();
        @(posedge clk24); #1 set_src(4'hF, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk24);
        #1 sample_ce = 1'b1;
        @(posedge clk24); #1 sample_ce = 1'b0;
        repeat (LAT + 3) @(posedge clk24);
        @(negedge clk24);
        check("overrun_pulses", 32'(ovr_cnt), 32'd1);
        check("overrun_valids", 32'(valid_cnt - v0), 32'd1);

        // Reset at E7 aborts the frame
        set_src(4'h0, 8'h80, 8'h00, 8'h00);
        @(negedge clk24);
        v0 = valid_cnt;
        start_frame();
        repeat (6) @(posedge clk24);
        #1 reset = 1'b1;
        @(posedge clk24); #1 reset = 1'b0;
        repeat (LAT + 3) @(posedge clk24);
        @(negedge clk24);
        check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("abort_left", 32'(o_left), 32'h8000);
        check("abort_right", 32'(o_right), 32'h8000);
        check("abort_busy", 32'(o_busy), 32'd0);
        exp_q.push_back({16'd3072, 16'd3072});
        start_frame();
        repeat (LAT + 3) @(posedge clk24);
        @(negedge clk24);

        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
